// File: rtl/simple_dual_port_ram_fifo_controller_if.sv
// Signal bundle between the FIFO controller, its user and the attached
// simple dual-port RAM. The controller takes the slave view.
interface simple_dual_port_ram_fifo_controller_if #(
  parameter int WIDTH         = 8,
  parameter int ADDRESS_WIDTH = 4
);
  logic                     write_enable;
  logic [WIDTH-1:0]         write_data;
  logic                     full;
  logic                     read_enable;
  logic [WIDTH-1:0]         read_data;
  logic                     empty;
  logic [ADDRESS_WIDTH:0]   level;
  logic                     memory_write_enable;
  logic [ADDRESS_WIDTH-1:0] memory_write_address;
  logic [WIDTH-1:0]         memory_write_data;
  logic                     memory_read_enable;
  logic [ADDRESS_WIDTH-1:0] memory_read_address;
  logic [WIDTH-1:0]         memory_read_data;

  modport slave (
    input  write_enable, write_data, read_enable, memory_read_data,
    output full, read_data, empty, level,
           memory_write_enable, memory_write_address, memory_write_data,
           memory_read_enable, memory_read_address
  );

  modport master (
    output write_enable, write_data, read_enable, memory_read_data,
    input  full, read_data, empty, level,
           memory_write_enable, memory_write_address, memory_write_data,
           memory_read_enable, memory_read_address
  );
endinterface

// File: rtl/simple_dual_port_ram_fifo_controller.sv
// Show-ahead FIFO controller for an external registered-read dual-port RAM;
// a prefetch slot plus one holding register hide the RAM read latency.
//
// state        | meaning
// SLOT_EMPTY   | nothing presented at read_data
// SLOT_PENDING | RAM read issued last cycle, read_data taken from RAM
// SLOT_HOLDING | word parked in the output register
module simple_dual_port_ram_fifo_controller #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input logic clock,
  input logic reset,
  simple_dual_port_ram_fifo_controller_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {SLOT_EMPTY, SLOT_PENDING, SLOT_HOLDING} slot_e;

  slot_e            slot_q, slot_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [AW:0]      ram_count;
  logic             pending, holding, occupied, full, push, pop, issue;

  always_comb begin
    pending   = (slot_q == SLOT_PENDING);
    holding   = (slot_q == SLOT_HOLDING);
    occupied  = pending | holding;
    ram_count = wr_ptr_q - rd_ptr_q;
    full      = (ram_count == DEPTH_CNT);
    push      = bus.write_enable & ~full & ~reset;
    pop       = bus.read_enable & occupied & ~reset;
    // Read only from registered count so a same-cycle write is never read back
    issue     = (ram_count != '0) & (occupied == pop) & ~reset;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    hold_d   = hold_q;
    slot_d   = SLOT_EMPTY;
    if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (issue) rd_ptr_d = rd_ptr_q + 1'b1;
    if (pending & ~pop) hold_d = bus.memory_read_data;
    if (issue)
      slot_d = SLOT_PENDING;
    else if (occupied & ~pop)
      slot_d = SLOT_HOLDING;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q   <= SLOT_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      hold_q   <= '0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      hold_q   <= hold_d;
    end
  end

  assign bus.full                 = full;
  assign bus.empty                = ~occupied;
  assign bus.read_data            = pending ? bus.memory_read_data : hold_q;
  assign bus.level                = ram_count + (AW+1)'(pending) + (AW+1)'(holding);
  assign bus.memory_write_enable  = push;
  assign bus.memory_write_address = wr_ptr_q[AW-1:0];
  assign bus.memory_write_data    = bus.write_data;
  assign bus.memory_read_enable   = issue;
  assign bus.memory_read_address  = rd_ptr_q[AW-1:0];
endmodule
